dcache_port_arbiter: RTL and testbench

DCACHE_PORT_ARBITER -- requirements
Module: dcache_port_arbiter

---
 rtl/dcache_port_arbiter_if.sv | 37 +++
 rtl/dcache_port_arbiter.sv | 125 ++++++++++++
 tb/tb_dcache_port_arbiter.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/dcache_port_arbiter_if.sv
// Bundle between the memory functional units, the arbiter and the dcache
// read port.
//   master : requester/dcache side; drives req_en, req_addr, Dcache_data_out
//            and Dcache_valid_out, and observes the arbiter outputs.
//   slave  : the arbiter; observes the requests and dcache return, and drives
//            arb2Dcache_en/addr, grant, resp_valid/resp_data, timeout and busy.
`ifndef XLEN
`define XLEN 32
`endif

interface dcache_port_arbiter_if #(
  parameter int unsigned NUM_REQ = 4
);
  logic [NUM_REQ-1:0]             req_en;
  logic [NUM_REQ-1:0][`XLEN-1:0]  req_addr;
  logic [63:0]                    Dcache_data_out;
  logic                           Dcache_valid_out;
  logic                           arb2Dcache_en;
  logic [`XLEN-1:0]               arb2Dcache_addr;
  logic [NUM_REQ-1:0]             grant;
  logic [NUM_REQ-1:0]             resp_valid;
  logic [63:0]                    resp_data;
  logic                           timeout;
  logic                           busy;

  modport master (
    output req_en, req_addr, Dcache_data_out, Dcache_valid_out,
    input  arb2Dcache_en, arb2Dcache_addr, grant, resp_valid, resp_data,
           timeout, busy
  );

  modport slave (
    input  req_en, req_addr, Dcache_data_out, Dcache_valid_out,
    output arb2Dcache_en, arb2Dcache_addr, grant, resp_valid, resp_data,
           timeout, busy
  );
endinterface

// File: rtl/dcache_port_arbiter.sv
// Round-robin arbiter sharing one dcache read port among NUM_REQ load/store
// units. One request is owned at a time; the owner waits in WAIT until the
// dcache returns valid data, the owner drops its request, or MAX_WAIT cycles
// pass.
// Ports:
//   clock  : single clock, all state updates on posedge
//   reset  : synchronous active-low reset
//   bus    : dcache_port_arbiter_if.slave (requests, dcache return, grant,
//            response, timeout and busy)
`ifndef XLEN
`define XLEN 32
`endif

module dcache_port_arbiter #(
  parameter int unsigned NUM_REQ  = 4,
  parameter int unsigned MAX_WAIT = 255
) (
  input  logic                  clock,
  input  logic                  reset,
  dcache_port_arbiter_if.slave  bus
);

  localparam int unsigned IDX_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned CNT_W  = (MAX_WAIT > 1) ? $clog2(MAX_WAIT + 1) : 1;
  localparam int unsigned ADDR_W = `XLEN;

  typedef enum logic {IDLE, WAIT} state_t;

  state_t              state_q;
  logic [IDX_W-1:0]    rr_ptr_q;
  logic [IDX_W-1:0]    owner_q;
  logic [CNT_W-1:0]    cnt_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [NUM_REQ-1:0]  grant_q;
  logic                timeout_q;

  logic                sel_found;
  logic [IDX_W-1:0]    sel_idx;
  logic [IDX_W-1:0]    nxt_ptr;
  logic                own_en;
  logic                hit;

  // First requester at or after rr_ptr, wrapping modulo NUM_REQ.
  always_comb begin
    int unsigned cand;
    cand      = 0;
    sel_found = 1'b0;
    sel_idx   = '0;
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      cand = (32'(rr_ptr_q) + 32'(i)) % NUM_REQ;
      if (!sel_found && bus.req_en[IDX_W'(cand)]) begin
        sel_found = 1'b1;
        sel_idx   = IDX_W'(cand);
      end
    end
  end

  // Pointer to the requester after the current owner.
  always_comb begin
    nxt_ptr = '0;
    if (owner_q != IDX_W'(NUM_REQ - 1)) nxt_ptr = owner_q + IDX_W'(1);
  end

  // Response is combinational so a first-cycle dcache hit completes at once;
  // gated by reset so nothing leaks out while reset is held.
  always_comb begin
    own_en = bus.req_en[owner_q];
    hit    = reset && (state_q == WAIT) && own_en && bus.Dcache_valid_out;
  end

  // Arbitration FSM.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q   <= IDLE;
      rr_ptr_q  <= '0;
      owner_q   <= '0;
      cnt_q     <= '0;
      addr_q    <= '0;
      grant_q   <= '0;
      timeout_q <= 1'b0;
    end else begin
      timeout_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (sel_found) begin
            state_q <= WAIT;
            owner_q <= sel_idx;
            addr_q  <= bus.req_addr[sel_idx];
            grant_q <= NUM_REQ'(1) << sel_idx;
            cnt_q   <= '0;
          end
        end
        WAIT: begin
          // Squash (owner dropped) wins over a simultaneous valid.
          if (!own_en || bus.Dcache_valid_out) begin
            state_q  <= IDLE;
            rr_ptr_q <= nxt_ptr;
            addr_q   <= '0;
            grant_q  <= '0;
          end else if (cnt_q == CNT_W'(MAX_WAIT - 1)) begin
            // This cycle brings the count to MAX_WAIT: give up.
            state_q   <= IDLE;
            rr_ptr_q  <= nxt_ptr;
            addr_q    <= '0;
            grant_q   <= '0;
            cnt_q     <= cnt_q + CNT_W'(1);
            timeout_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.arb2Dcache_en   = (state_q == WAIT);
  assign bus.busy            = (state_q == WAIT);
  assign bus.arb2Dcache_addr = addr_q;
  assign bus.grant           = grant_q;
  assign bus.timeout         = timeout_q;
  assign bus.resp_valid      = hit ? grant_q : '0;
  assign bus.resp_data       = hit ? bus.Dcache_data_out : 64'd0;

endmodule

// File: tb/tb_dcache_port_arbiter.sv
// Directed bench for dcache_port_arbiter (NUM_REQ=4, MAX_WAIT=4).
module tb_dcache_port_arbiter;

  logic clock;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  dcache_port_arbiter_if #(.NUM_REQ(4)) bus ();

  dcache_port_arbiter #(.NUM_REQ(4), .MAX_WAIT(4)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  logic [3:0]  exp_g;
  logic [31:0] exp_a;

  initial begin
    reset                = 1'b0;
    bus.req_en           = '0;
    bus.req_addr         = '0;
    bus.Dcache_valid_out = 1'b0;
    bus.Dcache_data_out  = '0;

    // Reset state
    step(); step(); #1;
    check("rst_en",    64'(bus.arb2Dcache_en),   64'd0);
    check("rst_addr",  64'(bus.arb2Dcache_addr), 64'd0);
    check("rst_grant", 64'(bus.grant),           64'd0);
    check("rst_rv",    64'(bus.resp_valid),      64'd0);
    check("rst_rd",    bus.resp_data,            64'd0);
    check("rst_to",    64'(bus.timeout),         64'd0);
    check("rst_busy",  64'(bus.busy),            64'd0);

    // Single request, first-cycle hit
    reset = 1'b1;
    step();
    bus.req_en      = 4'b0010;
    bus.req_addr[1] = 32'h100;
    #1;
    check("s_idle_grant", 64'(bus.grant), 64'd0);
    check("s_idle_busy",  64'(bus.busy),  64'd0);
    step();
    bus.Dcache_valid_out = 1'b1;
    bus.Dcache_data_out  = 64'hAABB;
    bus.req_addr[1]      = 32'h200;
    #1;
    check("s_grant", 64'(bus.grant),           64'h2);
    check("s_addr",  64'(bus.arb2Dcache_addr), 64'h100);
    check("s_en",    64'(bus.arb2Dcache_en),   64'd1);
    check("s_busy",  64'(bus.busy),            64'd1);
    check("s_rv",    64'(bus.resp_valid),      64'h2);
    check("s_rd",    bus.resp_data,            64'hAABB);
    step();
    bus.req_en           = '0;
    bus.Dcache_valid_out = 1'b0;
    #1;
    check("s_after_busy",  64'(bus.busy),       64'd0);
    check("s_after_grant", 64'(bus.grant),      64'd0);
    check("s_after_rv",    64'(bus.resp_valid), 64'd0);

    // Stray valid in IDLE
    bus.Dcache_valid_out = 1'b1;
    bus.Dcache_data_out  = 64'h1234;
    #1;
    check("stray_rv", 64'(bus.resp_valid), 64'd0);
    check("stray_rd", bus.resp_data,       64'd0);
    step();
    check("stray_busy", 64'(bus.busy), 64'd0);
    bus.Dcache_valid_out = 1'b0;

    // Round robin from a fresh reset
    reset = 1'b0;
    step();
    reset  = 1'b1;
    bus.req_en = 4'b1111;
    for (int i = 0; i < 4; i++) bus.req_addr[i] = 32'h1000 + 32'(i) * 32'h10;
    bus.Dcache_valid_out = 1'b1;
    bus.Dcache_data_out  = 64'hD00D;
    #1;
    check("rr_idle0", 64'(bus.grant), 64'd0);
    for (int k = 0; k < 5; k++) begin
      exp_g = 4'b0001 << (k % 4);
      exp_a = 32'h1000 + 32'(k % 4) * 32'h10;
      step();
      check($sformatf("rr_grant%0d", k), 64'(bus.grant),           64'(exp_g));
      check($sformatf("rr_addr%0d", k),  64'(bus.arb2Dcache_addr), 64'(exp_a));
      check($sformatf("rr_rv%0d", k),    64'(bus.resp_valid),      64'(exp_g));
      step();
      check($sformatf("rr_gap%0d", k),   64'(bus.grant),           64'd0);
    end
    bus.req_en           = '0;
    bus.Dcache_valid_out = 1'b0;
    #1;

    // Squash of requester 2 on its second WAIT cycle
    bus.req_en      = 4'b0100;
    bus.req_addr[2] = 32'h300;
    step();
    check("sq_grant", 64'(bus.grant),      64'h4);
    check("sq_rv1",   64'(bus.resp_valid), 64'd0);
    step();
    bus.req_en           = '0;
    bus.Dcache_valid_out = 1'b1;
    bus.Dcache_data_out  = 64'hEEEE;
    #1;
    check("sq_rv2", 64'(bus.resp_valid), 64'd0);
    check("sq_rd2", bus.resp_data,       64'd0);
    step();
    bus.Dcache_valid_out = 1'b0;
    bus.req_en           = 4'b1001;
    #1;
    check("sq_idle_busy",  64'(bus.busy),  64'd0);
    check("sq_idle_grant", 64'(bus.grant), 64'd0);
    step();
    check("sq_next_grant", 64'(bus.grant), 64'h8);
    bus.Dcache_valid_out = 1'b1;
    #1;
    check("sq_next_rv", 64'(bus.resp_valid), 64'h8);
    step();
    bus.req_en           = '0;
    bus.Dcache_valid_out = 1'b0;
    #1;

    // Timeout after 4 WAIT cycles
    bus.req_en = 4'b0001;
    for (int c = 1; c <= 4; c++) begin
      step();
      check($sformatf("to_busy_c%0d", c), 64'(bus.busy),    64'd1);
      check($sformatf("to_pulse_c%0d", c), 64'(bus.timeout), 64'd0);
    end
    step();
    check("to_pulse", 64'(bus.timeout),    64'd1);
    check("to_busy",  64'(bus.busy),       64'd0);
    check("to_rv",    64'(bus.resp_valid), 64'd0);
    check("to_grant", 64'(bus.grant),      64'd0);
    step();
    check("to_once",   64'(bus.timeout), 64'd0);
    check("to_regrant", 64'(bus.grant),  64'h1);
    bus.req_en = '0;
    step();

    // Reset while in WAIT
    bus.req_en = 4'b1000;
    step();
    check("rw_grant", 64'(bus.grant), 64'h8);
    reset = 1'b0;
    step();
    check("rw_en",    64'(bus.arb2Dcache_en),   64'd0);
    check("rw_addr",  64'(bus.arb2Dcache_addr), 64'd0);
    check("rw_grant0", 64'(bus.grant),          64'd0);
    check("rw_busy",  64'(bus.busy),            64'd0);
    check("rw_rv",    64'(bus.resp_valid),      64'd0);
    reset = 1'b1;
    step();
    check("rw_regrant", 64'(bus.grant),           64'h8);
    check("rw_readdr",  64'(bus.arb2Dcache_addr), 64'h1030);
    bus.Dcache_valid_out = 1'b1;
    bus.Dcache_data_out  = 64'h5A5A;
    #1;
    check("rw_rv2", 64'(bus.resp_valid), 64'h8);
    check("rw_rd2", bus.resp_data,       64'h5A5A);
    step();
    bus.req_en           = '0;
    bus.Dcache_valid_out = 1'b0;
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
